// File: rtl/jump_controller.sv
// Vertical jump physics for a sprite: GROUND/RISE/FALL state machine driven
// by a per-frame tick, with a one-entry request latch so a button press that
// arrives between ticks is not lost. Smaller yout means higher on screen.
module jump_controller #(
   parameter int unsigned Y_W      = 7,
   parameter int unsigned VEL_W    = 5,
   parameter int unsigned GROUND_Y = 108,
   parameter int unsigned Y_MIN    = 0,
   parameter int unsigned BIG_V0   = 9,
   parameter int unsigned SMALL_V0 = 7,
   parameter int unsigned DROP_V   = 4,
   parameter int unsigned GRAVITY  = 1,
   parameter int unsigned V_MAX    = 8
) (
   input  logic           clk,
   input  logic           reset,      // asynchronous, active low
   input  logic           tick,
   input  logic [2:0]     operation,
   output logic [Y_W-1:0] yout,
   output logic           airborne,
   output logic           landed
);

   typedef enum logic [1:0] {
      GROUND = 2'd0,
      RISE   = 2'd1,
      FALL   = 2'd2
   } state_t;

   // y arithmetic is done one bit wider so a borrow or overflow is visible
   localparam int unsigned AW = Y_W + 1;

   localparam logic [2:0]       OP_BIG   = 3'b001;
   localparam logic [2:0]       OP_SMALL = 3'b010;
   localparam logic [2:0]       OP_DROP  = 3'b100;

   localparam logic [AW-1:0]    GROUND_A = AW'(GROUND_Y);
   localparam logic [AW-1:0]    YMIN_A   = AW'(Y_MIN);
   localparam logic [Y_W-1:0]   GROUND_YV = Y_W'(GROUND_Y);
   localparam logic [Y_W-1:0]   YMIN_YV   = Y_W'(Y_MIN);
   localparam logic [VEL_W-1:0] BIG_V    = VEL_W'(BIG_V0);
   localparam logic [VEL_W-1:0] SMALL_V  = VEL_W'(SMALL_V0);
   localparam logic [VEL_W-1:0] DROP_VV  = VEL_W'(DROP_V);
   localparam logic [VEL_W-1:0] GRAV_V   = VEL_W'(GRAVITY);
   localparam logic [VEL_W:0]   GRAV_W   = (VEL_W+1)'(GRAVITY);
   localparam logic [VEL_W:0]   VMAX_W   = (VEL_W+1)'(V_MAX);
   localparam logic [VEL_W-1:0] VMAX_V   = VEL_W'(V_MAX);

   // speed minus gravity, floored at zero
   function automatic logic [VEL_W-1:0] sub_grav(input logic [VEL_W-1:0] v);
      sub_grav = (v > GRAV_V) ? (v - GRAV_V) : '0;
   endfunction

   // speed plus gravity, capped at terminal velocity
   function automatic logic [VEL_W-1:0] add_grav(input logic [VEL_W-1:0] v);
      logic [VEL_W:0] s;
      s = {1'b0, v} + GRAV_W;
      add_grav = (s > VMAX_W) ? VMAX_V : s[VEL_W-1:0];
   endfunction

   state_t           state_q, state_d;
   logic [Y_W-1:0]   yout_q, yout_d;
   logic [VEL_W-1:0] spd_q, spd_d;
   logic [2:0]       req_q, req_d;
   logic             req_vld_q, req_vld_d;
   logic             airborne_q, airborne_d;
   logic             landed_q, landed_d;

   logic             op_valid;
   logic [2:0]       cmd;

   // per-tick motion: either an upward step or a downward step
   logic             do_up, do_dn, up_to_fall, ceil_hit;
   logic [VEL_W-1:0] up_v, up_spd, dn_v;
   logic [AW-1:0]    y_ext, y_dn;
   logic [Y_W-1:0]   y_up;

   assign op_valid = (operation == OP_BIG) || (operation == OP_SMALL) ||
                     (operation == OP_DROP);

   // request latch: first valid one-hot request wins until a tick consumes it
   always_comb begin
      req_d     = req_q;
      req_vld_d = req_vld_q;
      cmd       = 3'b000;
      if (tick) begin
         cmd       = req_vld_q ? req_q : (op_valid ? operation : 3'b000);
         req_d     = 3'b000;
         req_vld_d = 1'b0;
      end else if (!req_vld_q && op_valid) begin
         req_d     = operation;
         req_vld_d = 1'b1;
      end
   end

   // choose this tick's motion from state and the consumed request
   always_comb begin
      do_up      = 1'b0;
      do_dn      = 1'b0;
      up_v       = '0;
      up_spd     = '0;
      up_to_fall = 1'b0;
      dn_v       = '0;
      if (tick) begin
         unique case (state_q)
            GROUND: begin
               // drop on the ground is meaningless and is discarded
               if (cmd == OP_BIG) begin
                  do_up  = 1'b1;
                  up_v   = BIG_V;
                  up_spd = sub_grav(BIG_V);
               end else if (cmd == OP_SMALL) begin
                  do_up  = 1'b1;
                  up_v   = SMALL_V;
                  up_spd = sub_grav(SMALL_V);
               end
            end
            RISE: begin
               if (cmd == OP_DROP) begin
                  // rising speed is discarded; fall starts at DROP_V
                  do_dn = 1'b1;
                  dn_v  = DROP_VV;
               end else begin
                  do_up      = 1'b1;
                  up_v       = spd_q;
                  up_spd     = sub_grav(spd_q);
                  up_to_fall = (spd_q == '0) || (sub_grav(spd_q) == '0);
               end
            end
            FALL: begin
               do_dn = 1'b1;
               if (cmd == OP_DROP)
                  dn_v = (spd_q > DROP_VV) ? spd_q : DROP_VV;
               else
                  dn_v = add_grav(spd_q);
            end
            default: ;
         endcase
      end
   end

   // apply the motion, clamping at ceiling and ground
   always_comb begin
      state_d  = state_q;
      yout_d   = yout_q;
      spd_d    = spd_q;
      landed_d = 1'b0;
      y_ext    = {1'b0, yout_q};
      y_up     = yout_q - Y_W'(up_v);
      y_dn     = y_ext + AW'(dn_v);
      // y - v < Y_MIN (borrow included) is the same as y < v + Y_MIN
      ceil_hit = y_ext < (AW'(up_v) + YMIN_A);
      if (do_up) begin
         if (ceil_hit) begin
            yout_d  = YMIN_YV;
            spd_d   = '0;
            state_d = FALL;
         end else begin
            yout_d  = y_up;
            spd_d   = up_spd;
            state_d = up_to_fall ? FALL : RISE;
         end
      end else if (do_dn) begin
         if (y_dn >= GROUND_A) begin
            yout_d   = GROUND_YV;
            spd_d    = '0;
            state_d  = GROUND;
            landed_d = 1'b1;
         end else begin
            yout_d  = y_dn[Y_W-1:0];
            spd_d   = dn_v;
            state_d = FALL;
         end
      end
      airborne_d = (state_d != GROUND);
   end

   // state, position, speed, latch and registered flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= GROUND;
         yout_q     <= GROUND_YV;
         spd_q      <= '0;
         req_q      <= 3'b000;
         req_vld_q  <= 1'b0;
         airborne_q <= 1'b0;
         landed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         yout_q     <= yout_d;
         spd_q      <= spd_d;
         req_q      <= req_d;
         req_vld_q  <= req_vld_d;
         airborne_q <= airborne_d;
         landed_q   <= landed_d;
      end
   end

   assign yout     = yout_q;
   assign airborne = airborne_q;
   assign landed   = landed_q;

endmodule

// File: tb/tb_jump_controller.sv
// Directed bench for jump_controller: trajectories with hand-computed rows,
// request-latch arbitration, ceiling clamp (small ground instance) and reset.
module tb_jump_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic [2:0] operation = 3'b000;
   logic [6:0] yout, yout20;
   logic       airborne, landed, airborne20, landed20;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   jump_controller dut (
      .clk(clk), .reset(reset), .tick(tick), .operation(operation),
      .yout(yout), .airborne(airborne), .landed(landed)
   );

   jump_controller #(.GROUND_Y(20)) dut20 (
      .clk(clk), .reset(reset), .tick(tick), .operation(operation),
      .yout(yout20), .airborne(airborne20), .landed(landed20)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // one tick cycle carrying op, preceded by one idle cycle
   task automatic step(input logic [2:0] op);
      @(negedge clk);
      tick = 1'b1;
      operation = op;
      @(negedge clk);
      tick = 1'b0;
      operation = 3'b000;
   endtask

   // present op on a non-tick cycle
   task automatic idle_op(input logic [2:0] op);
      @(negedge clk);
      operation = op;
      @(negedge clk);
      operation = 3'b000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   int big_seq[19]   = '{99,91,84,78,73,69,66,64,63,64,66,69,73,78,84,91,99,107,108};
   int small_seq[14] = '{101,95,90,86,83,81,80,81,83,86,90,95,101,108};
   int clamp_seq[9]  = '{11,3,0,1,3,6,10,15,20};

   initial begin
      // asynchronous reset with no clock edge in between
      #2 reset = 1'b0;
      #1;
      chk("rst yout", yout, 108);
      chk("rst airborne", airborne, 0);
      chk("rst landed", landed, 0);
      @(negedge clk);
      reset = 1'b1;

      // big jump full trajectory
      for (int i = 0; i < 19; i++) begin
         step(i == 0 ? 3'b001 : 3'b000);
         chk($sformatf("big y%0d", i), yout, big_seq[i]);
         chk($sformatf("big land%0d", i), landed, (i == 18) ? 1 : 0);
         chk($sformatf("big air%0d", i), airborne, (i == 18) ? 0 : 1);
      end
      @(negedge clk);
      chk("big land drop", landed, 0);
      chk("big idle y", yout, 108);

      // small jump, exact ground hit, then relaunch on the next tick
      do_reset();
      for (int i = 0; i < 14; i++) begin
         step(i == 0 ? 3'b010 : 3'b000);
         chk($sformatf("small y%0d", i), yout, small_seq[i]);
      end
      chk("small landed", landed, 1);
      step(3'b001);
      chk("relaunch y", yout, 99);
      chk("relaunch landed", landed, 0);
      chk("relaunch air", airborne, 1);

      // drop mid-rise, jump requests ignored in flight
      do_reset();
      step(3'b001); step(3'b000); step(3'b000);
      chk("drop pre y", yout, 84);
      idle_op(3'b100);
      chk("drop latched no move", yout, 84);
      step(3'b000);
      chk("drop y0", yout, 88);
      step(3'b001);
      chk("drop y1 nojump", yout, 93);
      step(3'b010);
      chk("drop y2 nojump", yout, 99);
      step(3'b000);
      chk("drop y3", yout, 106);
      step(3'b000);
      chk("drop y4", yout, 108);
      chk("drop landed", landed, 1);

      // ceiling clamp with GROUND_Y = 20
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step(i == 0 ? 3'b001 : 3'b000);
         chk($sformatf("clamp y%0d", i), yout20, clamp_seq[i]);
      end
      chk("clamp landed", landed20, 1);

      // reset mid-rise takes effect without a clock edge
      do_reset();
      step(3'b001); step(3'b000); step(3'b000); step(3'b000);
      chk("midrise pre y", yout, 78);
      #2 reset = 1'b0;
      #1;
      chk("midrise rst y", yout, 108);
      chk("midrise rst air", airborne, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrise no landed", landed, 0);
      step(3'b000);
      chk("midrise stays", yout, 108);

      // latch: first request wins
      do_reset();
      idle_op(3'b010);
      idle_op(3'b001);
      step(3'b000);
      chk("latch first wins", yout, 101);

      // non-one-hot ignored, drop on ground discarded, same-cycle request
      do_reset();
      idle_op(3'b011);
      step(3'b000);
      chk("bad op y", yout, 108);
      chk("bad op air", airborne, 0);
      step(3'b100);
      chk("ground drop y", yout, 108);
      step(3'b001);
      chk("same cycle y", yout, 99);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   // hard stop in case the stimulus ever stalls
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule

// File: doc/jump_controller.md
JUMP_CONTROLLER -- requirements
Module: jump_controller

Interface
REQ-001 SHALL: parameter Y_W, default 7, width of vertical position.
REQ-002 SHALL: parameter VEL_W, default 5, width of speed register.
REQ-003 SHALL: parameter GROUND_Y, default 108, rest/landing row; GROUND_Y <= 2^Y_W-1.
REQ-004 SHALL: parameter Y_MIN, default 0, ceiling row; Y_MIN < GROUND_Y.
REQ-005 SHALL: parameters BIG_V0 = 9, SMALL_V0 = 7, DROP_V = 4, GRAVITY = 1, V_MAX = 8 (defaults), all unsigned and < 2^VEL_W.
REQ-006 SHALL: clk  in  1  single clock, all state on rising edge.
REQ-007 SHALL: reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL: tick  in  1  one-cycle physics-step strobe, synchronous to clk.
REQ-009 SHALL: operation  in  3  one-hot request: 001 big jump, 010 small jump, 100 drop.
REQ-010 SHALL: yout  out  Y_W  current vertical position (smaller = higher).
REQ-011 SHALL: airborne  out  1  high whenever state is not GROUND.
REQ-012 SHALL: landed  out  1  one-cycle pulse marking touchdown.

Function
REQ-013 SHALL: state machine GROUND, RISE, FALL; speed register spd (VEL_W bits, unsigned magnitude).
REQ-014 SHALL: request latch: valid one-hot operation on any cycle captured when latch empty; non-one-hot or 000 ignored; later requests dropped while latch full (first wins).
REQ-015 SHALL: on tick, latch contents (or, if latch empty, operation on that same cycle) are consumed and the latch cleared.
REQ-016 SHALL: non-tick cycles leave yout, spd and state unchanged.
REQ-017 SHALL: GROUND + big jump at tick -> state RISE, yout -= BIG_V0, spd = BIG_V0-GRAVITY; small jump identical with SMALL_V0; drop on GROUND discarded.
REQ-018 SHALL: RISE at tick: yout -= spd, spd -= GRAVITY (saturate at 0); when spd before the step is 0 or after the step is 0 -> FALL.
REQ-019 SHALL: FALL at tick: spd = min(spd+GRAVITY, V_MAX); yout += new spd.
REQ-020 SHALL: drop consumed in RISE or FALL: state FALL, spd = max(DROP_V, spd if in FALL else 0), yout += that spd on the same tick.
REQ-021 SHALL: jump requests consumed while airborne are discarded (no double jump).
REQ-022 SHALL: all y arithmetic in Y_W+1 bits; result < Y_MIN (including borrow) -> yout = Y_MIN, spd = 0, state FALL.
REQ-023 SHALL: FALL result >= GROUND_Y -> yout = GROUND_Y, spd = 0, state GROUND; landed high for exactly the next clk cycle.
REQ-024 SHALL: airborne and landed are registered outputs; airborne updates in the same cycle as state.
REQ-025 SHALL: a jump request consumed on the tick after landing is honoured (landing then relaunch, no lost ticks).

Reset
REQ-026 SHALL: reset low -> immediately yout = GROUND_Y, state GROUND, spd = 0, latch empty, airborne = 0, landed = 0, regardless of clk or mid-jump state.
REQ-027 SHALL: first tick after reset release behaves as GROUND with any request captured after release.

Verification
REQ-028 SHALL: defaults, big jump at tick 1 -> yout 99,91,84,78,73,69,66,64,63 (apex, FALL), then 64,66,69,73,78,84,91,99,107,108; landed pulse once after 19th tick.
REQ-029 SHALL: small jump -> rise 101,95,90,86,83,81,80; fall 81,83,86,90,95,101,108 exact-hit lands at 14th tick.
REQ-030 SHALL: big jump, drop requested after 3rd tick (yout 84) -> 88,93,99,106,108 landed; jump requests during flight produce no change.
REQ-031 SHALL: GROUND_Y = 20, big jump -> 11, 3, then clamp 0 with spd 0 and FALL; subsequent fall 1,3,6,... to 20.
REQ-032 SHALL: reset asserted mid-rise (yout 78) -> yout 108, airborne 0 without waiting for clk; no landed pulse.
REQ-033 SHALL: two requests (small then big) between ticks -> small executed; operation 011 ignored; request on tick cycle with empty latch takes effect on that tick.
